// File: rtl/cpu_bist_pkg.sv
// cpu_bist_pkg: shared types and constants for the CPU board BIST sequencer.
//   - state_e        : sequencer FSM states
//   - vector counts  : NUM_VECTORS total, the first MUX_VECTORS exercise the mux
//   - SW_* / LED_*   : bit positions on the CPU's SW[9:0] / LEDR[9:0] buses
package cpu_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int MUX_VECTORS = 8;

  localparam int SW_W  = 10;
  localparam int LED_W = 10;
  localparam int IDX_W = 4;
  localparam int ERR_W = 5;

  // Switch inputs of the CPU under test
  localparam int SW_IN0 = 0;
  localparam int SW_IN1 = 1;
  localparam int SW_SEL = 2;
  localparam int SW_A   = 7;
  localparam int SW_B   = 8;
  localparam int SW_CIN = 9;

  // LED outputs of the CPU under test
  localparam int LED_MUX  = 0;
  localparam int LED_COUT = 8;
  localparam int LED_S    = 9;

endpackage

// File: rtl/cpu_bist_golden.sv
// cpu_bist_golden: combinational vector table and golden model.
//   idx_i      [3:0] : vector index 0..15
//   vec_o      [9:0] : SW pattern to drive for this index
//   expected_o [9:0] : expected LEDR value (only bits set in mask_o matter)
//   mask_o     [9:0] : LEDR bits that are compared for this index
module cpu_bist_golden
  import cpu_bist_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [SW_W-1:0]  vec_o,
  output logic [LED_W-1:0] expected_o,
  output logic [LED_W-1:0] mask_o
);

  logic op_a, op_b, op_c;

  // The low three index bits are the operands in both phases.
  assign op_a = idx_i[2];
  assign op_b = idx_i[1];
  assign op_c = idx_i[0];

  always_comb begin
    vec_o      = '0;
    expected_o = '0;
    mask_o     = '0;
    if (idx_i < IDX_W'(MUX_VECTORS)) begin
      // Mux phase: sel=idx[2], in1=idx[1], in0=idx[0]
      vec_o[SW_SEL]       = op_a;
      vec_o[SW_IN1]       = op_b;
      vec_o[SW_IN0]       = op_c;
      expected_o[LED_MUX] = op_a ? op_b : op_c;
      mask_o[LED_MUX]     = 1'b1;
    end else begin
      // Full adder phase: A=idx[2], B=idx[1], Cin=idx[0]
      vec_o[SW_A]          = op_a;
      vec_o[SW_B]          = op_b;
      vec_o[SW_CIN]        = op_c;
      expected_o[LED_S]    = op_a ^ op_b ^ op_c;
      expected_o[LED_COUT] = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
      mask_o[LED_S]        = 1'b1;
      mask_o[LED_COUT]     = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_bist_sequencer.sv
// cpu_bist_sequencer: drives 16 fixed vectors onto the CPU's SW inputs, waits a
// settle time for each, and checks the CPU's LEDR outputs against a golden model.
//   clk, reset (async, active-high)
//   start      : one-cycle run request, honoured in IDLE or DONE
//   sw_out     : drives CPU SW[9:0]
//   ledr_in    : CPU LEDR[9:0]
//   busy       : run in progress
//   done       : run finished, held until next start/reset
//   pass       : valid with done; 1 when no vector mismatched
//   err_count  : number of mismatching vectors (0..16)
//   fail_valid : a mismatch has been seen this run
//   first_fail : index of the first mismatching vector
module cpu_bist_sequencer
  import cpu_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [SW_W-1:0]  sw_out,
  input  logic [LED_W-1:0] ledr_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] first_fail
);

  // The counter is loaded with SETTLE_CYCLES-1, so it only needs to hold that.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW_W-1:0]    sw_q, sw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [IDX_W-1:0]   ff_q, ff_d;

  logic [SW_W-1:0]    gold_vec;
  logic [LED_W-1:0]   gold_exp;
  logic [LED_W-1:0]   gold_mask;
  logic               mismatch;
  logic [ERR_W-1:0]   err_inc;

  cpu_bist_golden u_golden (
    .idx_i      (idx_q),
    .vec_o      (gold_vec),
    .expected_o (gold_exp),
    .mask_o     (gold_mask)
  );

  assign mismatch = |((ledr_in ^ gold_exp) & gold_mask);
  // Error count including the vector currently being checked.
  assign err_inc  = err_q + ERR_W'(mismatch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_DRIVE: begin
        sw_d    = gold_vec;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_inc;
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          // A start on this edge is not seen: DONE is only entered here.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
          sw_d    = '0;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_DRIVE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sw_out     = sw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_cpu_bist_sequencer.sv
// Scoreboard bench for cpu_bist_sequencer. Two instances: u_dut0 (default
// settle time) against a behavioural CPU with selectable faults, and u_dut1
// (SETTLE_CYCLES=1) against a CPU model whose LEDR lags SW by 1 or 2 cycles.
module tb_cpu_bist_sequencer;

  localparam int K_SW     = 0;  // compare sw_out at a given cycle
  localparam int K_STAT   = 1;  // compare busy/done at a given cycle
  localparam int K_ZERO   = 2;  // all outputs zero at a given cycle
  localparam int K_RESULT = 3;  // compare run result when done rises

  typedef struct {
    int         kind;
    int         cyc;
    logic [9:0] sw;
    logic       busy;
    logic       done;
    logic [4:0] err;
    logic       fv;
    logic [3:0] ff;
    logic       pass;
    string      name;
  } exp_t;

  // Hand-derived SW patterns for indices 0..15.
  localparam logic [9:0] VEC [16] = '{
    10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007,
    10'h000, 10'h200, 10'h100, 10'h300, 10'h080, 10'h280, 10'h180, 10'h380
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  int         fault = 0;
  bit         lag2 = 1'b0;
  int         cyc = 0;

  logic [9:0] sw0, ledr0, sw1, ledr1;
  logic       busy0, done0, pass0, fv0;
  logic [4:0] err0;
  logic [3:0] ff0;
  logic       busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] ff1;
  logic [9:0] st1 = '0;
  logic [9:0] st2 = '0;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passed = 0;
  bit   tb_end = 1'b0;
  logic done0_prev = 1'b0;
  logic done1_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CPU: 2x1 mux on LEDR[0], full adder on LEDR[9:8], filler elsewhere.
  function automatic logic [9:0] cpu_model(input logic [9:0] sw, input int flt);
    logic a, b, c, s, co;
    logic [9:0] l;
    a  = sw[7];
    b  = sw[8];
    c  = sw[9];
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    l  = 10'b0010101010;
    l[0] = sw[2] ? sw[1] : sw[0];
    l[9] = s;
    l[8] = co;
    case (flt)
      1: l[0] = 1'b0;
      2: l[9] = 1'b0;
      3: begin l[9] = co; l[8] = s; end
      default: ;
    endcase
    return l;
  endfunction

  assign ledr0 = cpu_model(sw0, fault);

  always @(posedge clk) begin
    st1 <= cpu_model(sw1, 0);
    st2 <= st1;
  end
  assign ledr1 = lag2 ? st2 : st1;

  cpu_bist_sequencer #(.SETTLE_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .sw_out(sw0), .ledr_in(ledr0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail(ff0)
  );

  cpu_bist_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .sw_out(sw1), .ledr_in(ledr1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail(ff1)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit   rose0;
    bit   rose1;
    exp_t e;
    rose0 = done0 && !done0_prev;
    rose1 = done1 && !done1_prev;
    done0_prev <= done0;
    done1_prev <= done1;

    for (int k = 0; k < 8; k++) begin
      if (q0.size() == 0) break;
      e = q0[0];
      if (e.kind == K_RESULT) begin
        if (!rose0) break;
        void'(q0.pop_front());
        rose0 = 1'b0;
        chk({e.name, ".done_cycle"}, cyc, e.cyc);
        chk({e.name, ".err_count"}, err0, e.err);
        chk({e.name, ".fail_valid"}, fv0, e.fv);
        chk({e.name, ".first_fail"}, ff0, e.ff);
        chk({e.name, ".pass"}, pass0, e.pass);
        $display("run %s done at cycle %0d err=%0d fv=%0d ff=%0d pass=%0d",
                 e.name, cyc, err0, fv0, ff0, pass0);
      end else if (e.cyc < cyc) begin
        void'(q0.pop_front());
        checks++;
        $display("FAIL %s: sample at cycle %0d not reached in order (now %0d)", e.name, e.cyc, cyc);
      end else if (e.cyc == cyc) begin
        void'(q0.pop_front());
        case (e.kind)
          K_SW: chk(e.name, sw0, e.sw);
          K_STAT: begin
            chk({e.name, ".busy"}, busy0, e.busy);
            chk({e.name, ".done"}, done0, e.done);
          end
          default: begin
            chk({e.name, ".outputs"},
                {22'd0, sw0, busy0, done0, pass0, err0, fv0, ff0}, 0);
          end
        endcase
      end else begin
        break;
      end
    end
    if (rose0) begin
      checks++;
      $display("FAIL dut0_done: unexpected rise at cycle %0d, expected none", cyc);
    end

    if (rose1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL dut1_done: unexpected rise at cycle %0d, expected none", cyc);
      end else begin
        e = q1.pop_front();
        chk({e.name, ".done_cycle"}, cyc, e.cyc);
        chk({e.name, ".err_count"}, err1, e.err);
        chk({e.name, ".fail_valid"}, fv1, e.fv);
        chk({e.name, ".first_fail"}, ff1, e.ff);
        chk({e.name, ".pass"}, pass1, e.pass);
        $display("run %s done at cycle %0d err=%0d fv=%0d ff=%0d pass=%0d",
                 e.name, cyc, err1, fv1, ff1, pass1);
      end
    end

    if (tb_end) begin
      while (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        $display("FAIL %s: expected event at cycle %0d never observed", e.name, e.cyc);
      end
      while (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        $display("FAIL %s: expected done never observed", e.name);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push0(input int kind, input int c, input logic [9:0] sw,
                       input logic b, input logic d, input string name);
    exp_t e;
    e = '{kind: kind, cyc: c, sw: sw, busy: b, done: d, err: 5'd0, fv: 1'b0,
          ff: 4'd0, pass: 1'b0, name: name};
    q0.push_back(e);
  endtask

  task automatic push_res(input bit which, input int c, input int err, input bit fv,
                          input int ff, input bit p, input string name);
    exp_t e;
    e = '{kind: K_RESULT, cyc: c, sw: 10'd0, busy: 1'b0, done: 1'b1,
          err: 5'(err), fv: fv, ff: 4'(ff), pass: p, name: name};
    if (which) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic pulse_start0(output int s);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_start1(output int s);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 200 && !(done0 && !busy0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 200 && !(done1 && !busy1); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Plain fault run on dut0: latency 16*(4+2)=96.
  task automatic run0(input int flt, input int err, input bit fv, input int ff,
                      input bit p, input string name);
    int s;
    fault = flt;
    pulse_start0(s);
    push_res(1'b0, s + 96, err, fv, ff, p, name);
    wait_done0();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    // Reset state
    push0(K_ZERO, 1, 10'd0, 1'b0, 1'b0, "reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Run 1: good CPU; walk of sw_out checked at DRIVE and CHECK cycles.
    fault = 0;
    pulse_start0(s);
    for (int i = 0; i < 16; i++) begin
      push0(K_SW, s + 6 * i + 1, VEC[i], 1'b0, 1'b0, $sformatf("good.sw_drive%0d", i));
      push0(K_SW, s + 6 * i + 5, VEC[i], 1'b0, 1'b0, $sformatf("good.sw_check%0d", i));
    end
    push_res(1'b0, s + 96, 0, 1'b0, 0, 1'b1, "good");
    push0(K_SW, s + 96, 10'd0, 1'b0, 1'b0, "good.sw_after_done");
    wait_done0();

    // Run 2: LEDR[0] stuck at 0, start pulses mid-run and on the DONE-entry edge.
    fault = 1;
    pulse_start0(s);
    push0(K_STAT, s + 30, 10'd0, 1'b1, 1'b0, "mux0.mid_run");
    push_res(1'b0, s + 96, 4, 1'b1, 1, 1'b0, "mux_stuck0");
    push0(K_STAT, s + 98, 10'd0, 1'b0, 1'b1, "mux0.no_restart");
    while (cyc < s + 10) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    while (cyc < s + 50) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    while (cyc < s + 95) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    wait_done0();

    // Runs 3, 4: sum stuck at 0; sum/carry swapped.
    run0(2, 4, 1'b1, 9, 1'b0, "sum_stuck0");
    run0(3, 6, 1'b1, 9, 1'b0, "sum_cout_swap");

    // Run 5: reset asserted 40 cycles into a run aborts it asynchronously.
    fault = 0;
    pulse_start0(s);
    push0(K_STAT, s + 40, 10'd0, 1'b1, 1'b0, "abort.busy_before_reset");
    push0(K_ZERO, s + 41, 10'd0, 1'b0, 1'b0, "abort.async_clear");
    push0(K_ZERO, s + 43, 10'd0, 1'b0, 1'b0, "abort.idle_after_release");
    while (cyc < s + 40) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Run 6: clean run after the abort.
    run0(0, 0, 1'b0, 0, 1'b1, "after_abort");

    // Runs 7, 8: SETTLE_CYCLES=1 instance, latency 16*3=48.
    lag2 = 1'b0;
    pulse_start1(s);
    push_res(1'b1, s + 48, 0, 1'b0, 0, 1'b1, "lag1");
    wait_done1();

    // Two-cycle lag: each vector sees the previous vector's response.
    lag2 = 1'b1;
    pulse_start1(s);
    push_res(1'b1, s + 48, 10, 1'b1, 1, 1'b0, "lag2");
    wait_done1();

    repeat (4) @(negedge clk);
    tb_end = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_bist_sequencer.md
Name: cpu_bist_sequencer

Overview:
- Hardware stimulus/response engine for the CPU board interface. It drives the CPU's SW[9:0] inputs and samples its LEDR[9:0] outputs.
- On each start it walks 16 fixed vectors: 8 for the 2x1 mux, then 8 for the full adder. For each vector it waits a settle time, checks LEDR against a golden model, and counts mismatches.
- Sits on the board side of the SW/LEDR interface: SW feeds into the CPU, and the CPU's LEDR comes back to this block.

Parameters:
- SETTLE_CYCLES, 4: cycles sw_out is held before ledr_in is sampled; legal range ≥1.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run; honoured only in IDLE or DONE.
- sw_out  out  10  drives CPU SW[9:0].
- ledr_in  in  10  CPU LEDR[9:0].
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE, held until the next start or reset.
- pass  out  1  valid only while done=1; 1 when err_count=0.
- err_count  out  5  number of mismatching vectors, range 0..16.
- fail_valid  out  1  set on the first mismatch of a run.
- first_fail  out  4  index of the first mismatching vector.

Behaviour:
- Reset, asynchronous: state=IDLE, sw_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, idx=0, settle count=0.
- Reset asserted mid-run aborts the run immediately. Nothing from that run is retained.
- States are IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE, on an edge with start=1:
  - go to DRIVE; idx=0.
  - clear err_count, fail_valid, first_fail, done and pass.
  - busy=1.
- DRIVE, one cycle: at the edge, sw_out←vec(idx), count←SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: count decrements each edge. At the edge where count=0, go to CHECK.
- CHECK, one cycle: at the edge, sample ledr_in and compare it with expected(idx).
  - On mismatch: err_count+1. If fail_valid=0, also set first_fail=idx and fail_valid=1.
  - If idx=15: go to DONE, busy=0, done=1, pass=(final err_count==0), sw_out←0.
  - Otherwise: idx+1, go to DRIVE.
- Per-vector cost is SETTLE_CYCLES+2 cycles. done rises 16·(SETTLE_CYCLES+2) edges after the start edge: 96 cycles at the default.
- sw_out holds each vector through its CHECK cycle and changes only at the next DRIVE edge. ledr_in is therefore stable for SETTLE_CYCLES+1 cycles before it is sampled.
- Vector encoding; unlisted SW bits are 0:
  - idx 0–7, mux phase: {SW[2]=sel, SW[1]=in1, SW[0]=in0} = idx[2:0].
  - idx 8–15, adder phase: SW[7]=A=idx[2], SW[8]=B=idx[1], SW[9]=Cin=idx[0].
- Expected values; only these bits are compared, all other LEDR bits are ignored:
  - Mux phase: LEDR[0] = sel ? in1 : in0.
  - Adder phase: LEDR[9] = A^B^Cin (sum), LEDR[8] = majority(A,B,Cin) (carry out).
- start while busy=1 is ignored; the run continues unchanged.
- start on the same edge that enters DONE is ignored. A restart requires start=1 while state=DONE.
- err_count cannot exceed 16, so it needs no saturation logic.

Decomposition:
- Package cpu_bist_pkg holds:
  - the state enum;
  - NUM_VECTORS=16 and MUX_VECTORS=8;
  - SW bit positions: SW_IN0=0, SW_IN1=1, SW_SEL=2, SW_A=7, SW_B=8, SW_CIN=9;
  - LED bit positions: LED_MUX=0, LED_COUT=8, LED_S=9.
- One combinational sub-module, cpu_bist_golden: takes idx and returns vec[9:0], expected[9:0] and mask[9:0].

Test Plan:
- Behavioural correct mux+adder on ledr_in, SETTLE_CYCLES=4, pulse start → sw_out steps through the 16 vectors; done=1 exactly 96 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
- LEDR[0] stuck at 0 → err_count=4 (idx 1,3,6,7), first_fail=1, pass=0; adder vectors all pass.
- LEDR[9] stuck at 0 → err_count=4 (idx 9,10,12,15), first_fail=9, pass=0.
- LEDR[8] and LEDR[9] swapped → err_count=6 (idx 9,10,11,12,13,14), first_fail=9.
- Start pulses during a run → no restart, same done timing. Reset asserted at cycle 40 → all outputs 0 immediately, state IDLE. A subsequent start completes a clean run with pass=1.
- SETTLE_CYCLES=1 with a model whose LEDR lags SW by one cycle → pass=1. The same model with 2 cycles of lag → failures reported.
